// File: rtl/ifetch_if.sv
// Fetch-unit bus bundle: instruction-memory read channel and decoder issue channel.
// master = ifetch side, slave = memory controller / decoder side.
interface ifetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;
    logic        inst_rdy;
    logic [31:0] inst;
    logic [31:0] inst_PC;
    logic        inst_is_Jump;

    modport master (
        output mem_req, mem_addr, inst_rdy, inst, inst_PC, inst_is_Jump,
        input  mem_done, mem_data
    );

    modport slave (
        input  mem_req, mem_addr, inst_rdy, inst, inst_PC, inst_is_Jump,
        output mem_done, mem_data
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch unit: one outstanding word read, JAL redirect, 4-entry issue queue.
// Define BTFN_PREDICT_EN to predict backward conditional branches as taken.
module ifetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic [31:0] rollback_pc,
    input  logic        stall,
    ifetch_if.master    bus
);
    localparam logic [6:0] OP_JAL = 7'b1101111;
`ifdef BTFN_PREDICT_EN
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

    state_t      state_reg;
    logic [31:0] fetch_pc_reg;
    logic [31:0] req_pc_reg;
    logic [1:0]  head_reg;
    logic [1:0]  tail_reg;
    logic [2:0]  count_reg;

    logic [31:0] q_inst [4];
    logic [31:0] q_pc   [4];
    logic [3:0]  q_jump;

    logic        push;
    logic        pop;
    logic [31:0] next_pc;
    logic        pred_jump;
    logic [31:0] j_imm;

    assign j_imm = {{11{bus.mem_data[31]}}, bus.mem_data[31], bus.mem_data[19:12],
                    bus.mem_data[20], bus.mem_data[30:21], 1'b0};

`ifdef BTFN_PREDICT_EN
    logic [31:0] b_imm;
    assign b_imm = {{19{bus.mem_data[31]}}, bus.mem_data[31], bus.mem_data[7],
                    bus.mem_data[30:25], bus.mem_data[11:8], 1'b0};
`endif

    // Static prediction on the word arriving from memory, relative to its own PC.
    always_comb begin
        next_pc   = req_pc_reg + 32'd4;
        pred_jump = 1'b0;
        if (bus.mem_data[6:0] == OP_JAL) begin
            next_pc   = req_pc_reg + j_imm;
            pred_jump = 1'b1;
        end
`ifdef BTFN_PREDICT_EN
        else if (bus.mem_data[6:0] == OP_BRANCH && b_imm[31]) begin
            next_pc   = req_pc_reg + b_imm;
            pred_jump = 1'b1;
        end
`endif
    end

    assign pop  = rdy & ~rollback & ~stall & (count_reg != 3'd0);
    assign push = rdy & ~rollback & (state_reg == FETCH) & bus.mem_done;

    assign bus.inst_rdy     = pop;
    assign bus.inst         = q_inst[head_reg];
    assign bus.inst_PC      = q_pc[head_reg];
    assign bus.inst_is_Jump = q_jump[head_reg];
    assign bus.mem_req      = (state_reg != IDLE);
    assign bus.mem_addr     = req_pc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= '0;
            req_pc_reg   <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else if (rdy) begin
            if (rollback) begin
                head_reg     <= tail_reg;
                count_reg    <= '0;
                fetch_pc_reg <= rollback_pc;
                // The memory read cannot be cancelled; wait out its response.
                if (state_reg != IDLE)
                    state_reg <= bus.mem_done ? IDLE : DISCARD;
            end else begin
                head_reg  <= head_reg + {1'b0, pop};
                tail_reg  <= tail_reg + {1'b0, push};
                count_reg <= count_reg + {2'b00, push} - {2'b00, pop};
                case (state_reg)
                    IDLE: begin
                        if (count_reg != 3'd4) begin
                            state_reg  <= FETCH;
                            req_pc_reg <= fetch_pc_reg;
                        end
                    end
                    FETCH: begin
                        if (bus.mem_done) begin
                            fetch_pc_reg <= next_pc;
                            state_reg    <= IDLE;
                        end
                    end
                    DISCARD: begin
                        if (bus.mem_done)
                            state_reg <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    // Queue storage needs no reset: count_reg alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[tail_reg] <= bus.mem_data;
            q_pc[tail_reg]   <= req_pc_reg;
            q_jump[tail_reg] <= pred_jump;
        end
    end
endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: behavioural memory, program-order stream model, directed and random phases.
module tb_ifetch;
    logic        clk = 1'b0;
    logic        rst, rdy, rollback, stall;
    logic [31:0] rollback_pc;

    ifetch_if bif();

    ifetch dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .rollback   (rollback),
        .rollback_pc(rollback_pc),
        .stall      (stall),
        .bus        (bif)
    );

    always #5 clk = ~clk;

`ifdef BTFN_PREDICT_EN
    localparam logic [31:0] EXP_BR_NEXT = 32'h20;
    localparam logic        EXP_BR_JUMP = 1'b1;
`else
    localparam logic [31:0] EXP_BR_NEXT = 32'h44;
    localparam logic        EXP_BR_JUMP = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic        j;
    } iss_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic        s_rst, s_rdy, s_stall, s_rb;
    logic [31:0] s_rbpc;
    logic [31:0] prog [256];
    bit          busy = 0;
    int          cnt = 0;
    int          lat_min = 3, lat_max = 3;
    logic [31:0] maddr = '0;
    logic        prev_req = 1'b0;
    logic [31:0] exp_pc = '0;
    iss_t        iss_q[$];
    logic [31:0] req_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL timeout_%s: awaited event never happened (cycle %0d)", name, cyc);
    endtask

    // Architectural successor of the word at pc: {predicted_taken, next_pc}.
    function automatic logic [32:0] predict(input logic [31:0] pc);
        logic [31:0] w;
        int          off;
        w = prog[pc[9:2]];
        if (w[6:0] == 7'b1101111) begin
            off = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
            return {1'b1, pc + off};
        end
`ifdef BTFN_PREDICT_EN
        if (w[6:0] == 7'b1100011) begin
            off = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
            if (off < 0) return {1'b1, pc + off};
        end
`endif
        return {1'b0, pc + 32'd4};
    endfunction

    // One cycle: apply inputs and memory response at negedge, then check the stream model.
    task automatic tick();
        logic [32:0] pr;
        @(negedge clk);
        rst = s_rst; rdy = s_rdy; stall = s_stall; rollback = s_rb; rollback_pc = s_rbpc;
        if (s_rst) begin
            busy = 0;
            bif.mem_done = 1'b0;
        end else if (!s_rdy) begin
            bif.mem_done = 1'b0;
        end else if (busy) begin
            if (cnt <= 1) begin
                bif.mem_done = 1'b1;
                bif.mem_data = prog[maddr[9:2]];
                busy = 0;
            end else begin
                cnt--;
                bif.mem_done = 1'b0;
            end
        end else begin
            bif.mem_done = 1'b0;
            if (bif.mem_req) begin
                busy  = 1;
                maddr = bif.mem_addr;
                cnt   = $urandom_range(lat_max, lat_min);
            end
        end
        if (bif.mem_req && !prev_req) req_q.push_back(bif.mem_addr);
        prev_req = bif.mem_req;
        #1;
        cyc++;
        if (s_rst) begin
            exp_pc = '0;
        end else begin
            if (!s_rdy || s_rb || s_stall) check("inst_rdy_blocked", bif.inst_rdy, 0);
            if (bif.inst_rdy) begin
                pr = predict(exp_pc);
                $display("issue cyc=%0d pc=%08h inst=%08h jump=%0d", cyc, bif.inst_PC, bif.inst, bif.inst_is_Jump);
                check("inst_PC", bif.inst_PC, exp_pc);
                check("inst", bif.inst, prog[exp_pc[9:2]]);
                check("inst_is_Jump", bif.inst_is_Jump, pr[32]);
                iss_q.push_back('{cyc, bif.inst_PC, bif.inst_is_Jump});
                exp_pc = pr[31:0];
            end
            if (s_rdy && s_rb) exp_pc = s_rbpc;
            if (s_rdy && !s_rb && bif.mem_done) done_cnt++;
        end
    endtask

    task automatic do_reset();
        s_rst = 1; s_rdy = 1; s_stall = 0; s_rb = 0; s_rbpc = '0;
        tick();
        tick();
        check("reset_mem_req", bif.mem_req, 0);
        check("reset_mem_addr", bif.mem_addr, 0);
        check("reset_inst_rdy", bif.inst_rdy, 0);
        s_rst = 0;
        iss_q.delete();
        req_q.delete();
        done_cnt = 0;
    endtask

    task automatic fill_addi();
        for (int i = 0; i < 256; i++) prog[i] = 32'h00100093;
    endtask

    task automatic wait_issues(input int n, input int budget, input string name);
        int k = 0;
        while (iss_q.size() < n && k < budget) begin tick(); k++; end
        if (iss_q.size() < n) timeout(name);
    endtask

    task automatic wait_reqs(input int n, input int budget, input string name);
        int k = 0;
        while (req_q.size() < n && k < budget) begin tick(); k++; end
        if (req_q.size() < n) timeout(name);
    endtask

    initial begin
        logic        snap_req;
        logic [31:0] snap_addr;
        int          k;
        logic [31:0] r;

        rst = 1; rdy = 1; stall = 0; rollback = 0; rollback_pc = '0;
        bif.mem_done = 0; bif.mem_data = '0;

        // Sequential ADDI stream
        fill_addi();
        do_reset();
        wait_issues(3, 100, "seq");
        check("seq_pc0", iss_q[0].pc, 32'h0);
        check("seq_pc1", iss_q[1].pc, 32'h4);
        check("seq_pc2", iss_q[2].pc, 32'h8);
        check("seq_jump", {iss_q[0].j, iss_q[1].j, iss_q[2].j}, 0);

        // JAL +0x100 at 0x8
        fill_addi();
        prog[2] = 32'h1000006F;
        do_reset();
        wait_issues(4, 200, "jal");
        wait_reqs(4, 50, "jal_req");
        check("jal_req3", req_q[3], 32'h108);
        check("jal_pc", iss_q[2].pc, 32'h8);
        check("jal_jump", iss_q[2].j, 1);
        check("jal_target_pc", iss_q[3].pc, 32'h108);

        // Stall: queue fills to four, then release drains back-to-back
        fill_addi();
        do_reset();
        s_stall = 1;
        repeat (60) tick();
        check("stall_pushes", done_cnt, 4);
        check("stall_mem_req", bif.mem_req, 0);
        check("stall_no_issue", iss_q.size(), 0);
        s_stall = 0;
        repeat (6) tick();
        if (iss_q.size() < 4) timeout("stall_release");
        for (int i = 0; i < 4; i++) check("stall_release_pc", iss_q[i].pc, 4 * i);
        for (int i = 1; i < 4; i++) check("stall_release_cyc", iss_q[i].cyc - iss_q[0].cyc, i);

        // Rollback to 0x200 while 0x10 is outstanding
        fill_addi();
        do_reset();
        k = 0;
        while (!(req_q.size() > 0 && req_q[$] == 32'h10) && k < 200) begin tick(); k++; end
        if (k >= 200) timeout("rb_wait_0x10");
        s_rb = 1; s_rbpc = 32'h200;
        tick();
        s_rb = 0;
        tick();
        check("rb_queue_empty", bif.inst_rdy, 0);
        k = req_q.size();
        wait_reqs(k + 1, 50, "rb_req");
        check("rb_next_addr", req_q[$], 32'h200);
        iss_q.delete();
        wait_issues(1, 50, "rb_issue");
        check("rb_first_pc", iss_q[0].pc, 32'h200);

        // Backward branch at 0x40, imm -0x20
        fill_addi();
        prog[16] = 32'hFE0000E3;
        do_reset();
        s_rb = 1; s_rbpc = 32'h40;
        tick();
        s_rb = 0;
        wait_reqs(2, 100, "br_req");
        check("br_req0", req_q[0], 32'h40);
        check("br_req1", req_q[1], EXP_BR_NEXT);
        wait_issues(1, 50, "br_issue");
        check("br_pc", iss_q[0].pc, 32'h40);
        check("br_jump", iss_q[0].j, EXP_BR_JUMP);

        // rdy low freezes a two-entry queue
        fill_addi();
        do_reset();
        s_stall = 1;
        k = 0;
        while (done_cnt < 2 && k < 100) begin tick(); k++; end
        if (done_cnt < 2) timeout("rdy_fill");
        tick();
        s_rdy = 0; s_stall = 0;
        tick();
        snap_req  = bif.mem_req;
        snap_addr = bif.mem_addr;
        repeat (5) begin
            tick();
            check("rdy_low_mem_req", bif.mem_req, snap_req);
            check("rdy_low_mem_addr", bif.mem_addr, snap_addr);
        end
        check("rdy_low_no_pop", iss_q.size(), 0);
        s_rdy = 1;
        wait_issues(2, 20, "rdy_resume");
        check("rdy_resume_pc0", iss_q[0].pc, 32'h0);
        check("rdy_resume_pc1", iss_q[1].pc, 32'h4);

        // Asynchronous reset mid-FETCH
        k = 0;
        while (!(bif.mem_req && bif.mem_addr != 0) && k < 100) begin tick(); k++; end
        if (k >= 100) timeout("rst_fetch");
        #2;
        rst = 1;
        #1;
        check("async_rst_mem_req", bif.mem_req, 0);
        check("async_rst_mem_addr", bif.mem_addr, 0);
        check("async_rst_inst_rdy", bif.inst_rdy, 0);
        s_rst = 1;
        tick();
        s_rst = 0;

        // Random program with random rdy/stall/rollback/reset and memory latency
        for (int i = 0; i < 256; i++) begin
            r = $urandom;
            case ($urandom % 5)
                0: prog[i] = {r[31:7], 7'b1101111};
                1: prog[i] = {r[31:7], 7'b1100011};
                2: prog[i] = {r[31:7], 7'b1100111};
                default: prog[i] = {r[31:7], 7'b0010011};
            endcase
        end
        lat_min = 1; lat_max = 4;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            s_rdy   = ($urandom % 10) != 0;
            s_stall = ($urandom % 5) == 0;
            s_rb    = ($urandom % 40) == 0;
            s_rbpc  = {22'd0, 8'($urandom), 2'b00};
            s_rst   = ($urandom % 400) == 0;
            tick();
        end
        check("random_liveness", iss_q.size() >= 300, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
